// File: rtl/bus_arb_pkg.sv
// Shared types, defaults and helpers for the round-robin bus arbiter.
// The optional grant timeout is enabled by defining BUS_ARB_TIMEOUT_EN.
package bus_arb_pkg;

    localparam int unsigned DefaultNumCores = 4;
    localparam int unsigned DefaultMaxHold  = 16;
    localparam int unsigned MaxCores        = 32;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

    function automatic logic [MaxCores-1:0] onehot(input logic [31:0] idx);
        logic [MaxCores-1:0] v;
        v = '0;
        v[idx[4:0]] = 1'b1;
        return v;
    endfunction

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [31:0] index(input logic [MaxCores-1:0] oh);
        logic [31:0] r;
        r = '0;
        for (int i = MaxCores - 1; i >= 0; i--) begin
            if (oh[i]) begin
                r = 32'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request strictly after last_grant, wrapping.
module rr_picker
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_CORES = DefaultNumCores,
    parameter int unsigned ID_W      = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [ID_W-1:0]      last_grant,
    output logic [ID_W-1:0]      pick,
    output logic                 any_req
);

    always_comb begin
        int unsigned idx;
        logic        found;
        idx     = 0;
        found   = 1'b0;
        pick    = '0;
        any_req = |req;
        for (int unsigned i = 1; i <= NUM_CORES; i++) begin
            idx = (32'(last_grant) + i) % NUM_CORES;
            if (!found && req[idx[ID_W-1:0]]) begin
                pick  = idx[ID_W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the shared snoop/memory bus, one registered one-hot grant.
// Define BUS_ARB_TIMEOUT_EN to force-revoke grants held for MAX_HOLD cycles.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_CORES = DefaultNumCores,
    parameter int unsigned ID_W      = $clog2(NUM_CORES),
    parameter int unsigned MAX_HOLD  = DefaultMaxHold
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CORES-1:0] req,
    input  logic [NUM_CORES-1:0] done,
    output logic [NUM_CORES-1:0] grant,
    output logic [ID_W-1:0]      grant_id,
    output logic                 bus_busy,
    output logic                 timeout_err
);

    localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

    arb_state_t           state_q;
    logic [NUM_CORES-1:0] grant_q;
    logic [ID_W-1:0]      grant_id_q;
    logic [ID_W-1:0]      last_grant_q;
    logic                 bus_busy_q;
    logic [HoldW-1:0]     hold_cnt_q;
    logic [ID_W-1:0]      pick;
    logic                 any_req;
    logic                 owner_release;

    rr_picker #(
        .NUM_CORES (NUM_CORES),
        .ID_W      (ID_W)
    ) u_rr_picker (
        .req        (req),
        .last_grant (last_grant_q),
        .pick       (pick),
        .any_req    (any_req)
    );

    // Only the owner's done/req matter; other cores are ignored while busy.
    assign owner_release = done[grant_id_q] | ~req[grant_id_q];

`ifdef BUS_ARB_TIMEOUT_EN
    logic timeout_q;
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            grant_id_q   <= '0;
            bus_busy_q   <= 1'b0;
            last_grant_q <= ID_W'(NUM_CORES - 1);
            hold_cnt_q   <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
        end else begin
`ifdef BUS_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q      <= NUM_CORES'(onehot(32'(pick)));
                        grant_id_q   <= pick;
                        bus_busy_q   <= 1'b1;
                        last_grant_q <= pick;
                        hold_cnt_q   <= '0;
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    if (hold_cnt_q != HoldW'(MAX_HOLD)) begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                    if (owner_release) begin
                        grant_q    <= '0;
                        bus_busy_q <= 1'b0;
                        state_q    <= IDLE;
                    end
`ifdef BUS_ARB_TIMEOUT_EN
                    // last_grant stays on the revoked core so the next pick rotates past it.
                    else if (hold_cnt_q == HoldW'(MAX_HOLD - 1)) begin
                        grant_q    <= '0;
                        bus_busy_q <= 1'b0;
                        timeout_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign bus_busy = bus_busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Table-driven bench for bus_arbiter: each record is one clock of inputs plus post-edge outputs.
module tb_bus_arbiter;

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] grant;
        logic [1:0] id;
        logic       busy;
        logic       to;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       bus_busy;
    logic       timeout_err;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec;
    int   n_bad;

    bus_arbiter #(
        .NUM_CORES (4),
        .ID_W      (2),
        .MAX_HOLD  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_id    (grant_id),
        .bus_busy    (bus_busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] dn,
                                input logic [3:0] g, input logic [1:0] id, input logic b);
        vec_t v;
        v.rst   = r;
        v.req   = rq;
        v.done  = dn;
        v.grant = g;
        v.id    = id;
        v.busy  = b;
        v.to    = 1'b0;
        return v;
    endfunction

    // Drive one clock of stimulus, then check the outputs registered at that edge.
    task automatic step(input vec_t v);
        vec_t e;
        reset = v.rst;
        req   = v.req;
        done  = v.done;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_vec++;
        if (grant !== e.grant || grant_id !== e.id || bus_busy !== e.busy ||
            timeout_err !== e.to) begin
            n_bad++;
            $display("FAIL vec %0d: grant=%b id=%0d busy=%b to=%b, expected grant=%b id=%0d busy=%b to=%b",
                     n_vec, grant, grant_id, bus_busy, timeout_err,
                     e.grant, e.id, e.busy, e.to);
        end
    endtask

    initial begin
        vec_t v;
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        req   = '0;
        done  = '0;

        // Reset state, then single request to core 2.
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2, 1));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2, 1));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2, 1));
        vecs.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, 2, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 2, 0));
        // Fairness from reset: 0,1,2,3,0 with an idle cycle between grants.
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        for (int c = 0; c < 4; c++) begin
            vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'(1 << c), 2'(c), 1));
            vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'(1 << c), 2'(c), 1));
            vecs.push_back(mk(0, 4'b1111, 4'(1 << c), 4'b0000, 2'(c), 0));
        end
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001, 0, 1));
        // Simultaneous done and req drop from the owner, then done while idle.
        vecs.push_back(mk(0, 4'b0000, 4'b0001, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0001, 4'b0000, 0, 0));
        // Foreign done ignored; owner done releases; pending core 0 next.
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 4'b0010, 1, 1));
        vecs.push_back(mk(0, 4'b0011, 4'b0001, 4'b0010, 1, 1));
        vecs.push_back(mk(0, 4'b0011, 4'b0000, 4'b0010, 1, 1));
        vecs.push_back(mk(0, 4'b0011, 4'b0010, 4'b0000, 1, 0));
        vecs.push_back(mk(0, 4'b0011, 4'b0000, 4'b0001, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0001, 4'b0000, 0, 0));
        // Withdrawal by core 3, then pending core 0.
        vecs.push_back(mk(0, 4'b1000, 4'b0000, 4'b1000, 3, 1));
        vecs.push_back(mk(0, 4'b1001, 4'b0000, 4'b1000, 3, 1));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 3, 0));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0001, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        // Re-grant to the same core still needs one idle cycle.
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0001, 0, 1));
        vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0001, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        // Reset mid-transaction restarts priority at core 0.
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2, 1));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 2, 1));
        vecs.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i]);
        end

        // Long hold by core 0 with core 1 pending.
        step(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        step(mk(0, 4'b0011, 4'b0000, 4'b0001, 0, 1));
`ifdef BUS_ARB_TIMEOUT_EN
        for (int k = 0; k < 7; k++) begin
            step(mk(0, 4'b0011, 4'b0000, 4'b0001, 0, 1));
        end
        v    = mk(0, 4'b0011, 4'b0000, 4'b0000, 0, 0);
        v.to = 1'b1;
        step(v);
        step(mk(0, 4'b0011, 4'b0000, 4'b0010, 1, 1));
        step(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0));
`else
        for (int k = 0; k < 20; k++) begin
            step(mk(0, 4'b0011, 4'b0000, 4'b0001, 0, 1));
        end
        v = mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        step(v);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
